// File: rtl/m_serialshifter.sv
// m_serialshifter
//   Multi-cycle shifter for SLL/SRL/SRA. The operand and shift amount are
//   latched on an accepted start. While at least 8 positions remain, the unit
//   shifts a whole byte per cycle. Below 8 it shifts one bit per cycle.
//   lastshift marks the final step, and done pulses once the result is valid.
//
// Parameters
//   HIGHLEVEL  0 = explicit ripple-borrow down-counter, 1 = behavioural subtract
//   BYTESTEP   1 = 8-bit steps while cnt>=8, 0 = 1-bit steps only
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request, accepted only while busy==0
//   op         00 SLL, 01 SRL, 11 SRA, 10 behaves as SRL
//   din        operand, sampled at the accepting edge
//   shamt      shift amount, sampled at the accepting edge
//   busy       registered, high while shift steps remain
//   lastshift  combinational, high in the cycle of the final shift step
//   done       registered one-cycle pulse, dout is final in that cycle
//   dout       result register, holds until the next accepted start or rst
//
// state | meaning
// IDLE  | waiting for start; dout holds the last result
// SHIFT | one shift step per cycle until cnt reaches zero

module m_serialshifter #(
    parameter int HIGHLEVEL = 0,
    parameter int BYTESTEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        lastshift,
    output logic        done,
    output logic [31:0] dout
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt, cnt_dec, step;
    logic [1:0]  opreg, opreg_nxt;
    logic        busy_nxt, done_nxt;
    logic [31:0] dout_nxt, shifted;
    logic        byte_step;

    // cnt>=8 is the same as either of the two upper count bits being set.
    assign byte_step = (BYTESTEP != 0) && (cnt[4:3] != 2'b00);
    assign step      = byte_step ? 5'd8 : 5'd1;
    assign lastshift = (state == SHIFT) && (cnt == step);

    always_comb begin
        shifted = byte_step ? {8'h00, dout[31:8]} : {1'b0, dout[31:1]};
        case (opreg)
            2'b00:   shifted = byte_step ? {dout[23:0], 8'h00} : {dout[30:0], 1'b0};
            2'b11:   shifted = byte_step ? {{8{dout[31]}}, dout[31:8]} : {dout[31], dout[31:1]};
            default: shifted = byte_step ? {8'h00, dout[31:8]} : {1'b0, dout[31:1]};
        endcase
    end

    // The step never exceeds cnt, so the decrement cannot wrap.
    generate
        if (HIGHLEVEL != 0) begin : g_dec_behav
            assign cnt_dec = cnt - step;
        end else begin : g_dec_chain
            logic borrow;
            always_comb begin
                borrow  = 1'b0;
                cnt_dec = '0;
                for (int i = 0; i < 5; i++) begin
                    cnt_dec[i] = cnt[i] ^ step[i] ^ borrow;
                    borrow     = (~cnt[i] & (step[i] | borrow)) | (cnt[i] & step[i] & borrow);
                end
            end
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        opreg_nxt = opreg;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    dout_nxt  = din;
                    cnt_nxt   = shamt;
                    opreg_nxt = op;
                    if (shamt != 5'd0) begin
                        state_nxt = SHIFT;
                        busy_nxt  = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                dout_nxt = shifted;
                cnt_nxt  = cnt_dec;
                if (lastshift) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            cnt   <= '0;
            opreg <= 2'b00;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            dout  <= dout_nxt;
            cnt   <= cnt_nxt;
            opreg <= opreg_nxt;
        end
    end

endmodule

// File: tb/tb_m_serialshifter.sv
// Testbench for m_serialshifter with default parameters (byte stepping enabled).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_m_serialshifter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] din = '0;
    logic [4:0]  shamt = '0;
    logic        busy, lastshift, done;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_serialshifter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .din       (din),
        .shamt     (shamt),
        .busy      (busy),
        .lastshift (lastshift),
        .done      (done),
        .dout      (dout)
    );

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00:   return d << s;
            2'b11:   return sd >>> s;
            default: return d >> s;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] s);
        return 1 + int'(s) / 8 + int'(s) % 8;
    endfunction

    // Issues one operation, starting right after a falling edge, and follows it to done.
    // With poke set, a junk start is driven every cycle the shifter is expected to be busy.
    task automatic do_shift(input string name, input logic [1:0] o, input logic [31:0] d,
                            input logic [4:0] s, input bit poke);
        logic [31:0] exp;
        int lat_exp, lat, ls_cnt, ls_cyc;
        exp     = ref_shift(o, d, s);
        lat_exp = ref_latency(s);
        lat = -1; ls_cnt = 0; ls_cyc = -1;
        start = 1'b1; op = o; din = d; shamt = s;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (lastshift) begin ls_cnt++; ls_cyc = k; end
            if (done) lat = k;
            checks++;
            if (busy !== (k < lat_exp)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, (k < lat_exp));
            end
            if (poke && k < lat_exp) begin
                start = 1'b1; op = 2'b00; din = 32'h0000_1234; shamt = 5'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != lat_exp) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, lat_exp);
        end
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s dout: got %h expected %h", name, dout, exp);
        end
        checks++;
        if (ls_cnt != ((s != 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s lastshift count: got %0d expected %0d", name, ls_cnt, (s != 0) ? 1 : 0);
        end
        if (s != 0) begin
            checks++;
            if (ls_cyc != lat_exp - 1) begin
                errors++;
                $display("FAIL %s lastshift cycle: got %0d expected %0d", name, ls_cyc, lat_exp - 1);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dout !== exp) begin
            errors++;
            $display("FAIL %s after done: got done=%b dout=%h expected done=0 dout=%h", name, done, dout, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
        checks++;
        if (dout !== 32'h0) begin errors++; $display("FAIL reset dout: got %h expected 0", dout); end
        checks++;
        if (lastshift !== 1'b0) begin errors++; $display("FAIL reset lastshift: got %b expected 0", lastshift); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_shift("sll31",   2'b00, 32'h0000_0001, 5'd31, 1'b0);
        do_shift("sra4",    2'b11, 32'h8000_0000, 5'd4,  1'b0);
        do_shift("srl4",    2'b01, 32'h8000_0000, 5'd4,  1'b0);
        do_shift("srl12",   2'b01, 32'hF000_000F, 5'd12, 1'b0);
        do_shift("op10_12", 2'b10, 32'hF000_000F, 5'd12, 1'b0);
        do_shift("zero",    2'b00, 32'hDEAD_BEEF, 5'd0,  1'b0);
        do_shift("ignore",  2'b11, 32'hC0DE_1357, 5'd20, 1'b1);
        do_shift("sra8",    2'b11, 32'h8765_4321, 5'd8,  1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int done_seen;
        start = 1'b1; op = 2'b00; din = 32'hA5A5_5A5A; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 32'h0 || lastshift !== 1'b0) begin
            errors++;
            $display("FAIL midreset state: got busy=%b done=%b dout=%h lastshift=%b expected 0 0 0 0",
                     busy, done, dout, lastshift);
        end
        rst = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset no done: got %0d pulses expected 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] db;
        int lat;
        db = $urandom;
        start = 1'b1; op = 2'b01; din = 32'hF000_000F; shamt = 5'd12;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
        end
        checks++;
        if (lat != 6 || dout !== 32'h000F_0000) begin
            errors++;
            $display("FAIL b2b first: got lat=%0d dout=%h expected lat=6 dout=000f0000", lat, dout);
        end
        // launch B in the done cycle of A
        start = 1'b1; op = 2'b11; din = db; shamt = 5'd9;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL b2b done drop: got %b expected 0", done); end
            end
            if (done) lat = k;
            start = 1'b0;
        end
        checks++;
        if (lat != ref_latency(5'd9) || dout !== ref_shift(2'b11, db, 5'd9)) begin
            errors++;
            $display("FAIL b2b second: got lat=%0d dout=%h expected lat=%0d dout=%h",
                     lat, dout, ref_latency(5'd9), ref_shift(2'b11, db, 5'd9));
        end
        // launch a zero-amount op in B's done cycle: done stays high one more cycle
        start = 1'b1; op = 2'b00; din = 32'h1357_9BDF; shamt = 5'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || dout !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL b2b zero: got done=%b dout=%h expected done=1 dout=13579bdf", done, dout);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] d;
        logic [4:0]  s;
        for (int i = 0; i < 25; i++) begin
            o = 2'($urandom_range(0, 3));
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            do_shift("random", o, d, s, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
